dcache: RTL

Direct-mapped, write-through, no-write-allocate data cache between the single-cycle datapath's memory port (ALU result as address, register write data, returned read data) and a slower word-wide backing memory with a request/acknowledge handshake. Read hits return data in the same cycle with no stall. Misses and all stores hold the processor with `stall` until the backing memory acknowledges.

---
 rtl/dcache.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/dcache.sv
// Direct-mapped, write-through, no-write-allocate data cache with one-word lines.
// Read hits complete combinationally; misses and stores stall the datapath until the backing memory acks.
module dcache #(
  parameter int INDEX_BITS = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] cpu_addr,
  input  logic        cpu_memread,
  input  logic        cpu_memwrite,
  input  logic [31:0] cpu_wdata,
  output logic [31:0] cpu_rdata,
  output logic        stall,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack
);

  localparam int LINES = 1 << INDEX_BITS;
  localparam int TAG_W = 30 - INDEX_BITS;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FILL  = 2'd1,
    ST_WRITE = 2'd2,
    ST_WDONE = 2'd3
  } state_t;

  state_t state_r, state_next_s;

  logic              valid_r [LINES];
  logic [TAG_W-1:0]  tag_r   [LINES];
  logic [31:0]       data_r  [LINES];

  logic              mem_req_r, mem_we_r;
  logic [31:0]       mem_addr_r, mem_wdata_r;

  logic [INDEX_BITS-1:0] cpu_idx_s, mem_idx_s;
  logic [TAG_W-1:0]      cpu_tag_s, mem_tag_s;
  logic                  cpu_hit_s, mem_hit_s;
  logic                  stall_s;
  logic [31:0]           rdata_s;
  logic                  addr_lsb_unused_s;

  // Lookups use the live CPU address in IDLE and the latched request address once a transfer is in flight.
  assign cpu_idx_s = cpu_addr[INDEX_BITS+1:2];
  assign cpu_tag_s = cpu_addr[31:INDEX_BITS+2];
  assign mem_idx_s = mem_addr_r[INDEX_BITS+1:2];
  assign mem_tag_s = mem_addr_r[31:INDEX_BITS+2];
  assign cpu_hit_s = valid_r[cpu_idx_s] && (tag_r[cpu_idx_s] == cpu_tag_s);
  assign mem_hit_s = valid_r[mem_idx_s] && (tag_r[mem_idx_s] == mem_tag_s);
  assign addr_lsb_unused_s = ^cpu_addr[1:0];

  // Next-state, stall and load-data decode.
  always_comb begin
    state_next_s = state_r;
    stall_s      = 1'b0;
    rdata_s      = 32'h0;
    case (state_r)
      ST_IDLE: begin
        if (cpu_memwrite) begin
          stall_s      = 1'b1;
          state_next_s = ST_WRITE;
        end else if (cpu_memread) begin
          if (cpu_hit_s) begin
            rdata_s = data_r[cpu_idx_s];
          end else begin
            stall_s      = 1'b1;
            state_next_s = ST_FILL;
          end
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_FILL: begin
        stall_s = 1'b1;
        if (mem_ack) begin
          state_next_s = ST_IDLE;
        end else begin
          state_next_s = ST_FILL;
        end
      end
      ST_WRITE: begin
        stall_s = 1'b1;
        if (mem_ack) begin
          state_next_s = ST_WDONE;
        end else begin
          state_next_s = ST_WRITE;
        end
      end
      ST_WDONE: state_next_s = ST_IDLE;
      default:  state_next_s = ST_IDLE;
    endcase
  end

  // State register, memory-side request registers and line storage updates.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= ST_IDLE;
      mem_req_r   <= 1'b0;
      mem_we_r    <= 1'b0;
      mem_addr_r  <= 32'h0;
      mem_wdata_r <= 32'h0;
      for (int i = 0; i < LINES; i++) begin
        valid_r[i] <= 1'b0;
      end
    end else begin
      state_r <= state_next_s;
      case (state_r)
        ST_IDLE: begin
          if (cpu_memwrite) begin
            mem_req_r   <= 1'b1;
            mem_we_r    <= 1'b1;
            mem_addr_r  <= {cpu_addr[31:2], 2'b00};
            mem_wdata_r <= cpu_wdata;
          end else if (cpu_memread && !cpu_hit_s) begin
            mem_req_r  <= 1'b1;
            mem_we_r   <= 1'b0;
            mem_addr_r <= {cpu_addr[31:2], 2'b00};
          end
        end
        ST_FILL: begin
          if (mem_ack) begin
            valid_r[mem_idx_s] <= 1'b1;
            tag_r[mem_idx_s]   <= mem_tag_s;
            data_r[mem_idx_s]  <= mem_rdata;
            mem_req_r          <= 1'b0;
          end
        end
        ST_WRITE: begin
          if (mem_ack) begin
            // Write-through without allocation: only an already-resident line is refreshed.
            if (mem_hit_s) begin
              data_r[mem_idx_s] <= mem_wdata_r;
            end
            mem_req_r <= 1'b0;
            mem_we_r  <= 1'b0;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign cpu_rdata = rdata_s;
  assign stall     = stall_s;
  assign mem_req   = mem_req_r;
  assign mem_we    = mem_we_r;
  assign mem_addr  = mem_addr_r;
  assign mem_wdata = mem_wdata_r;

endmodule
